// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants for the instruction encoder: opcodes,
// funct codes, ALU control codes, the request-kind enumeration and the
// encoder FSM state encoding, plus two helpers that assemble R- and I-format
// words.
package mips_pkg;

   // Request kinds presented on i_kind
   typedef enum logic [2:0] {
      K_R_ALU   = 3'd0,
      K_R_SHIFT = 3'd1,
      K_I_ALU   = 3'd2,
      K_LW      = 3'd3,
      K_SW      = 3'd4,
      K_BEQ     = 3'd5,
      K_BNE     = 3'd6,
      K_J       = 3'd7
   } kind_e;

   // Encoder FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FULL = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_XOR = 6'b100110;
   localparam logic [5:0] F_NOR = 6'b100111;
   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_SRL = 6'b000010;
   localparam logic [5:0] F_SRA = 6'b000011;
   localparam logic [5:0] F_ROR = 6'b000101;
   localparam logic [5:0] F_ROL = 6'b001001;

   // ALU control codes (what the decoder produces for each instruction)
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_NOR = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_ROR = 4'b1011;
   localparam logic [3:0] ALU_ROL = 4'b1100;

   // R-format word: {000000, rs, rt, rd, shamt, funct}
   function automatic logic [31:0] r_word(input logic [4:0] rs,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd,
                                          input logic [4:0] shamt,
                                          input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, shamt, funct};
   endfunction

   // I-format word: {op, rs, rt, imm16}
   function automatic logic [31:0] i_word(input logic [5:0]  op,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_enc_lut.sv
// Combinational encoding table: maps an abstract operation (kind, ALU control
// code, shift flag, register/immediate fields) to a 32-bit MIPS word and a
// legal flag. Only the J kind ignores the ALU code and shift flag; every other
// kind requires the shift flag that its decoding would produce (1 for
// R_SHIFT, 0 otherwise).
// Build option: INSTR_ENC_EXT_OPS_EN enables XOR/NOR, XORI and ROR/ROL;
// without it those codes are reported as illegal.
module instr_enc_lut
   import mips_pkg::*;
(
   input  kind_e       kind_i,
   input  logic [3:0]  alu_control_i,
   input  logic        shift_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  shamt_i,
   input  logic [25:0] imm_i,
   output logic [31:0] word_o,
   output logic        legal_o
);

   logic [5:0] code;

   // Look up funct/opcode for the requested kind and assemble the word
   always_comb begin
      word_o  = 32'd0;
      legal_o = 1'b0;
      code    = 6'd0;
      case (kind_i)
         K_R_ALU: begin
            legal_o = ~shift_i;
            case (alu_control_i)
               ALU_ADD: code = F_ADD;
               ALU_SUB: code = F_SUB;
               ALU_AND: code = F_AND;
               ALU_OR:  code = F_OR;
               ALU_SLT: code = F_SLT;
`ifdef INSTR_ENC_EXT_OPS_EN
               ALU_XOR: code = F_XOR;
               ALU_NOR: code = F_NOR;
`endif
               default: legal_o = 1'b0;
            endcase
            word_o = r_word(rs_i, rt_i, rd_i, shamt_i, code);
         end
         K_R_SHIFT: begin
            legal_o = shift_i;
            case (alu_control_i)
               ALU_SLL: code = F_SLL;
               ALU_SRL: code = F_SRL;
               ALU_SRA: code = F_SRA;
`ifdef INSTR_ENC_EXT_OPS_EN
               ALU_ROR: code = F_ROR;
               ALU_ROL: code = F_ROL;
`endif
               default: legal_o = 1'b0;
            endcase
            // Shifts take their operand from rt; rs is always encoded as 0
            word_o = r_word(5'd0, rt_i, rd_i, shamt_i, code);
         end
         K_I_ALU: begin
            legal_o = ~shift_i;
            case (alu_control_i)
               ALU_ADD: code = OP_ADDI;
               ALU_SLT: code = OP_SLTI;
               ALU_AND: code = OP_ANDI;
               ALU_OR:  code = OP_ORI;
`ifdef INSTR_ENC_EXT_OPS_EN
               ALU_XOR: code = OP_XORI;
`endif
               default: legal_o = 1'b0;
            endcase
            word_o = i_word(code, rs_i, rt_i, imm_i[15:0]);
         end
         K_LW: begin
            legal_o = ~shift_i & (alu_control_i == ALU_ADD);
            word_o  = i_word(OP_LW, rs_i, rt_i, imm_i[15:0]);
         end
         K_SW: begin
            legal_o = ~shift_i & (alu_control_i == ALU_ADD);
            word_o  = i_word(OP_SW, rs_i, rt_i, imm_i[15:0]);
         end
         K_BEQ: begin
            legal_o = ~shift_i & (alu_control_i == ALU_SUB);
            word_o  = i_word(OP_BEQ, rs_i, rt_i, imm_i[15:0]);
         end
         K_BNE: begin
            legal_o = ~shift_i & (alu_control_i == ALU_SUB);
            word_o  = i_word(OP_BNE, rs_i, rt_i, imm_i[15:0]);
         end
         K_J: begin
            legal_o = 1'b1;
            word_o  = {OP_J, imm_i};
         end
         default: begin
            legal_o = 1'b0;
            word_o  = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / imem writer. Accepts abstract operations over a
// valid/ready handshake, encodes each through instr_enc_lut and writes legal
// words to consecutive imem addresses one cycle after acceptance. Illegal
// requests are consumed but produce an o_err pulse instead of a write.
// Build option: INSTR_ENC_EXT_OPS_EN (extended ALU ops, see instr_enc_lut).
//
// Handshake: a request transfers on a rising edge where i_valid & o_ready are
// both high; o_ready depends on registered state only, so a source may hold
// i_valid and its payload until it sees o_ready without any combinational
// loop through this block.
module instr_encoder
   import mips_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [2:0]        i_kind,
   input  logic [3:0]        i_alu_control,
   input  logic              i_shift,
   input  logic [4:0]        i_rs,
   input  logic [4:0]        i_rt,
   input  logic [4:0]        i_rd,
   input  logic [4:0]        i_shamt,
   input  logic [25:0]       i_imm,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [31:0]       o_wr_data,
   output logic              o_err,
   output logic [7:0]        o_err_cnt,
   output logic [ADDR_W:0]   o_count,
   output logic              o_full,
   output logic              o_done
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   state_e              state_q;
   logic [ADDR_W:0]     count_q,   count_d;
   logic [ADDR_W-1:0]   addr_q,    addr_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [31:0]         wr_data_q;
   logic                err_q;
   logic                full_q;

   logic [31:0]         lut_word;
   logic                lut_legal;
   logic                accept;
   logic                write_fire;
   logic                err_fire;

   instr_enc_lut u_lut (
      .kind_i        (kind_e'(i_kind)),
      .alu_control_i (i_alu_control),
      .shift_i       (i_shift),
      .rs_i          (i_rs),
      .rt_i          (i_rt),
      .rd_i          (i_rd),
      .shamt_i       (i_shamt),
      .imm_i         (i_imm),
      .word_o        (lut_word),
      .legal_o       (lut_legal)
   );

   assign o_ready = (state_q == ST_RUN) && (count_q < DEPTH_C);
   assign accept  = i_valid & o_ready;

   // A start in the same cycle as an accepted request wins: the request is
   // consumed but discarded so the new program begins cleanly at address 0.
   assign write_fire = accept & lut_legal  & ~i_start;
   assign err_fire   = accept & ~lut_legal & ~i_start;

   // Next values of the word counter, write address and saturating error count
   always_comb begin
      count_d   = count_q;
      addr_d    = addr_q;
      err_cnt_d = err_cnt_q;
      if (i_start) begin
         count_d   = '0;
         addr_d    = '0;
         err_cnt_d = 8'd0;
      end else begin
         if (write_fire) begin
            count_d = count_q + 1'b1;
            addr_d  = addr_q + 1'b1;
         end
         if (err_fire && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   // FSM, counters and registered write/error outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         addr_q    <= '0;
         err_cnt_q <= 8'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 32'd0;
         err_q     <= 1'b0;
         full_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         addr_q    <= addr_d;
         err_cnt_q <= err_cnt_d;
         full_q    <= (count_d == DEPTH_C);
         wr_en_q   <= write_fire;
         err_q     <= err_fire;
         if (write_fire) begin
            wr_addr_q <= addr_q;
            wr_data_q <= lut_word;
         end
         if (i_start) begin
            state_q <= ST_RUN;
         end else begin
            case (state_q)
               ST_RUN: begin
                  // A word accepted alongside i_stop is still written
                  if (i_stop) begin
                     state_q <= ST_DONE;
                  end else if (count_d == DEPTH_C) begin
                     state_q <= ST_FULL;
                  end
               end
               ST_FULL: begin
                  if (i_stop) begin
                     state_q <= ST_DONE;
                  end
               end
               default: state_q <= state_q;
            endcase
         end
      end
   end

   assign o_wr_en   = wr_en_q;
   assign o_wr_addr = wr_addr_q;
   assign o_wr_data = wr_data_q;
   assign o_err     = err_q;
   assign o_err_cnt = err_cnt_q;
   assign o_count   = count_q;
   assign o_full    = full_q;
   assign o_done    = (state_q == ST_DONE);

endmodule
